flash_comparator: RTL and testbench

// - Registered magnitude comparator: one slice of the flash-ADC comparator bank.
// - Compares sampled input code vin against threshold vref (both unsigned).
// - Drives a_grt_b = 1 only when vin is strictly greater than vref.
// - One instance per ADC threshold; the bank outputs form the thermometer code for the encoder.

---
 rtl/flash_comparator_pkg.sv | 24 ++
 rtl/flash_comparator_cmp_core.sv | 32 +++
 rtl/flash_comparator.sv | 55 +++++
 tb/tb_flash_comparator.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/flash_comparator_pkg.sv
// Shared definitions for the flash-ADC comparator bank and its thermometer encoder.
package flash_comparator_pkg;

  // Width of the sampled input code and of each threshold code.
  localparam int ADC_WIDTH = 8;

  // Three-way compare outcome consumed by the thermometer encoder.
  typedef enum logic [1:0] {
    CMP_LT = 2'd0,
    CMP_EQ = 2'd1,
    CMP_GT = 2'd2
  } cmp_result_e;

  // Collapse the one-hot gt/eq/lt flags into the encoder's enum form.
  function automatic cmp_result_e flags_to_result(input logic gt, input logic eq);
    if (gt)
      return CMP_GT;
    else if (eq)
      return CMP_EQ;
    else
      return CMP_LT;
  endfunction

endpackage

// File: rtl/flash_comparator_cmp_core.sv
// Purely combinational unsigned magnitude compare of a against b.
// The first differing bit, scanning from the MSB down, decides the outcome.
module cmp_core
  import flash_comparator_pkg::*;
#(
  parameter int WIDTH = ADC_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gt,
  output logic             eq,
  output logic             lt,
  output cmp_result_e      result
);

  // MSB-first cascade: once a bit has decided the order, lower bits are ignored.
  always_comb begin
    gt = 1'b0;
    lt = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!gt && !lt) begin
        if (a[i] && !b[i])
          gt = 1'b1;
        else if (!a[i] && b[i])
          lt = 1'b1;
      end
    end
    eq     = !gt && !lt;
    result = flags_to_result(gt, eq);
  end

endmodule

// File: rtl/flash_comparator.sv
// One registered slice of the flash-ADC comparator bank: compares the sampled
// code vin against this slice's threshold vref with a single cycle of latency.
module flash_comparator
  import flash_comparator_pkg::*;
#(
  parameter int WIDTH = ADC_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] vin,
  input  logic [WIDTH-1:0] vref,
  output logic             a_grt_b,
  output logic             a_eq_b,
  output logic             a_lt_b,
  output logic             out_valid
);

  logic        cmp_gt;
  logic        cmp_eq;
  logic        cmp_lt;
  cmp_result_e cmp_result;

  cmp_core #(.WIDTH(WIDTH)) u_cmp_core (
    .a      (vin),
    .b      (vref),
    .gt     (cmp_gt),
    .eq     (cmp_eq),
    .lt     (cmp_lt),
    .result (cmp_result)
  );

  // Capture the compare flags only on valid samples so they hold across idle
  // cycles; reset clears everything and wins over a simultaneous valid sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_grt_b   <= 1'b0;
      a_eq_b    <= 1'b0;
      a_lt_b    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        a_grt_b <= (cmp_result == CMP_GT);
        a_eq_b  <= cmp_eq;
        a_lt_b  <= cmp_lt;
      end
    end
  end

  // The enum result already carries gt; keep the raw flag as a cross-check net.
  logic unused_gt;
  assign unused_gt = cmp_gt;

endmodule

// File: tb/tb_flash_comparator.sv
// Self-checking bench for flash_comparator: directed cases from the datasheet
// examples followed by randomized traffic against a behavioural model.
module tb_flash_comparator;

  localparam int W = 8;
  localparam logic [W-1:0] MAXV = 8'd255;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] vin;
  logic [W-1:0] vref;
  logic         a_grt_b;
  logic         a_eq_b;
  logic         a_lt_b;
  logic         out_valid;

  int checks;
  int errors;

  // Behavioural model state: what the outputs should show after the last edge.
  logic exp_gt;
  logic exp_eq;
  logic exp_lt;
  logic exp_valid;

  flash_comparator #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .vin       (vin),
    .vref      (vref),
    .a_grt_b   (a_grt_b),
    .a_eq_b    (a_eq_b),
    .a_lt_b    (a_lt_b),
    .out_valid (out_valid)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point reporting tag, observed and expected values.
  task automatic check_bit(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  // Compare all four outputs against the model, plus the one-hot property.
  task automatic check_output(input string tag);
    check_bit({tag, ".out_valid"}, out_valid, exp_valid);
    check_bit({tag, ".a_grt_b"}, a_grt_b, exp_gt);
    check_bit({tag, ".a_eq_b"}, a_eq_b, exp_eq);
    check_bit({tag, ".a_lt_b"}, a_lt_b, exp_lt);
    if (exp_valid)
      check_bit({tag, ".onehot"}, ($countones({a_grt_b, a_eq_b, a_lt_b}) == 1), 1'b1);
  endtask

  // Drive one cycle of inputs, advance past the edge, update the model, check.
  task automatic apply_stimulus(input string tag, input logic r, input logic v,
                                input logic [W-1:0] a, input logic [W-1:0] b);
    rst      = r;
    in_valid = v;
    vin      = a;
    vref     = b;
    @(posedge clk);
    #1;
    if (r) begin
      exp_gt    = 1'b0;
      exp_eq    = 1'b0;
      exp_lt    = 1'b0;
      exp_valid = 1'b0;
    end else begin
      exp_valid = v;
      if (v) begin
        exp_gt = (int'(a) > int'(b));
        exp_eq = (int'(a) == int'(b));
        exp_lt = (int'(a) < int'(b));
      end
    end
    check_output(tag);
  endtask

  initial begin
    logic         r_rst;
    logic         r_valid;
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;

    checks    = 0;
    errors    = 0;
    exp_gt    = 1'b0;
    exp_eq    = 1'b0;
    exp_lt    = 1'b0;
    exp_valid = 1'b0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    vin       = '0;
    vref      = '0;

    $display("[TB] starting flash_comparator bench");

    // Reset state, including reset winning over a valid sample.
    apply_stimulus("reset0", 1'b1, 1'b0, 8'd0, 8'd0);
    apply_stimulus("reset_prio", 1'b1, 1'b1, 8'd200, 8'd1);

    // Datasheet examples.
    apply_stimulus("gt_167_105", 1'b0, 1'b1, 8'd167, 8'd105);
    apply_stimulus("lt_38_87", 1'b0, 1'b1, 8'd38, 8'd87);
    apply_stimulus("eq_85_85", 1'b0, 1'b1, 8'd85, 8'd85);

    // Extremes.
    apply_stimulus("max_gt_zero", 1'b0, 1'b1, MAXV, 8'd0);
    apply_stimulus("zero_lt_max", 1'b0, 1'b1, 8'd0, MAXV);
    apply_stimulus("max_eq_max", 1'b0, 1'b1, MAXV, MAXV);
    apply_stimulus("zero_eq_zero", 1'b0, 1'b1, 8'd0, 8'd0);
    apply_stimulus("max_gt_254", 1'b0, 1'b1, MAXV, 8'd254);
    apply_stimulus("msb_only", 1'b0, 1'b1, 8'h80, 8'h7F);
    apply_stimulus("lsb_only", 1'b0, 1'b1, 8'h00, 8'h01);

    // Back-to-back valid samples with alternating outcomes.
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0)
        apply_stimulus("pipe_gt", 1'b0, 1'b1, 8'd167, 8'd105);
      else
        apply_stimulus("pipe_lt", 1'b0, 1'b1, 8'd38, 8'd87);
    end

    // Idle cycles: out_valid drops, flags hold the last result.
    apply_stimulus("idle_hold0", 1'b0, 1'b0, 8'd255, 8'd0);
    apply_stimulus("idle_hold1", 1'b0, 1'b0, 8'd0, 8'd255);

    // Reset mid-stream, then first result one cycle after release.
    apply_stimulus("pre_rst", 1'b0, 1'b1, 8'd200, 8'd100);
    apply_stimulus("mid_rst", 1'b1, 1'b1, 8'd10, 8'd20);
    apply_stimulus("post_rst", 1'b0, 1'b1, 8'd10, 8'd20);

    // Randomized traffic, biased toward equal and extreme codes.
    for (int i = 0; i < 400; i++) begin
      r_rst   = ($urandom_range(0, 31) == 0);
      r_valid = ($urandom_range(0, 3) != 0);
      r_a     = W'($urandom_range(0, 255));
      case ($urandom_range(0, 5))
        0:       r_b = r_a;
        1:       r_b = MAXV;
        2:       r_b = 8'd0;
        default: r_b = W'($urandom_range(0, 255));
      endcase
      apply_stimulus("random", r_rst, r_valid, r_a, r_b);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
